// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer around one shared full-adder cell
//
// Adds two WIDTH-bit unsigned operands LSB first, one bit per clock, using a single
// full-adder cell built from two half adders and an OR.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   a, b       operands, captured on the accepting edge
//   busy       high while bits are being processed
//   done       one-cycle pulse, sum/carry_out valid
//   sum        registered result, held until the next completion
//   carry_out  registered final carry, held with sum

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             c_q,     c_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;

  // Shared adder cell: first half adder on the operand bits, second folds in the carry.
  logic ha1_s, ha1_c, ha2_s, ha2_c;
  logic sum_bit, carry_next;
  logic [WIDTH-1:0] res_shift;

  assign ha1_s      = a_q[0] ^ b_q[0];
  assign ha1_c      = a_q[0] & b_q[0];
  assign ha2_s      = ha1_s ^ c_q;
  assign ha2_c      = ha1_s & c_q;
  assign sum_bit    = ha2_s;
  assign carry_next = ha1_c | ha2_c;

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign res_shift  = {sum_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d = res_shift;
        c_d   = carry_next;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        if (cnt_q == CNT_LAST) begin
          sum_d   = res_shift;
          cout_d  = carry_next;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl

module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry_out;

  int vectors;
  int miscompares;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to completion, checking latency and result.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] es, input logic ec, input string tag);
    int n;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 16'(n), 16'd8);
    check({tag, "_done"}, {15'd0, done}, 16'd1);
    check({tag, "_sum"}, {8'd0, sum}, {8'd0, es});
    check({tag, "_cout"}, {15'd0, carry_out}, {15'd0, ec});
    @(negedge clk);
    check({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
  endtask

  initial begin
    int n;
    int dones;
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_sum", {8'd0, sum}, 16'd0);
    check("rst_cout", {15'd0, carry_out}, 16'd0);
    rst_n = 1'b1;

    // Basic operations
    run_op(8'h00, 8'h00, 8'h00, 1'b0, "zero");
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, "ff_01");
    run_op(8'h80, 8'h80, 8'h00, 1'b1, "80_80");
    run_op(8'hA5, 8'h5A, 8'hFF, 1'b0, "a5_5a");

    // start during RUN is ignored; operand changes mid-run have no effect
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", {15'd0, busy}, 16'd1);
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h55; b = 8'hAA;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("ign_done", {15'd0, done}, 16'd1);
    check("ign_sum", {8'd0, sum}, 16'h0046);
    check("ign_cout", {15'd0, carry_out}, 16'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    check("ign_no_second_op", 16'(dones), 16'd0);

    // Idle with toggling operands: outputs hold
    for (int i = 0; i < 20; i++) begin
      a = 8'(i * 37); b = ~8'(i * 11);
      @(negedge clk);
      check("idle_sum", {8'd0, sum}, 16'h0046);
      check("idle_done", {15'd0, done}, 16'd0);
    end

    // start held high: one op per 10 cycles, busy low 2 cycles between runs
    a = 8'h0F; b = 8'h01; start = 1'b1;
    dones = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      check("hold_busy", {15'd0, busy}, {15'd0, ((cyc % 10) < 8)});
      check("hold_done", {15'd0, done}, {15'd0, ((cyc % 10) == 8)});
      if (done === 1'b1) begin
        dones++;
        check("hold_sum", {8'd0, sum}, 16'h0010);
      end
      if (cyc == 29) start = 1'b0;
    end
    check("hold_done_count", 16'(dones), 16'd3);

    // Reset in the middle of a run
    @(negedge clk);
    a = 8'hF0; b = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", {15'd0, busy}, 16'd0);
    check("mid_done", {15'd0, done}, 16'd0);
    check("mid_sum", {8'd0, sum}, 16'd0);
    check("mid_cout", {15'd0, carry_out}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("mid_no_done", 16'(dones), 16'd0);
    run_op(8'h01, 8'h02, 8'h03, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer that reuses one 1-bit adder cell over WIDTH cycles to add two WIDTH-bit operands, LSB first.
- The cell is two half adders plus an OR for carry: sum_bit = a_i^b_i^c, carry = (a_i&b_i)|((a_i^b_i)&c).
- Sits between a requester (start/done handshake) and the shared bit-level adder datapath.
- Trades area for latency; it is the controller that feeds, steps and collects the half-adder datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result; holds until next completion.
- carry_out  output  1  registered final carry; holds with sum.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, carry_out=0; bit counter, operand shift regs and internal carry cleared.
- States: IDLE, RUN, DONE.
- IDLE: on edge with start=1, load a/b into shift regs, clear carry, counter=0, go RUN. start=0 stays IDLE.
- RUN: each edge processes bit[counter]:
  - shift result reg right with new sum bit entering MSB;
  - update carry; shift operands right; counter+1.
  - On edge processing bit WIDTH-1: copy result to sum, final carry to carry_out, go DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency: busy rises after accepting edge E0. Bits processed on E1..E_WIDTH. done high in the cycle after E_WIDTH. sum/carry_out change only on E_WIDTH.
- Throughput: with start held high, one operation per WIDTH+2 cycles (re-accepted in IDLE after DONE).
- start in RUN or DONE is ignored, not queued.
- a/b changes after the accepting edge have no effect on the in-flight result.
- Arithmetic: unsigned, modulo 2^WIDTH in sum; overflow bit in carry_out.
- Counter width is clog2(WIDTH). Terminal value is WIDTH-1; no wrap past it.
- Reset mid-RUN: in-flight operation discarded; sum/carry_out cleared to 0; no done pulse.
- Reset release: first edge with rst_n high and start=1 is accepted normally.

Test Plan:
- WIDTH=8, a=0x00, b=0x00, start 1 cycle -> busy high 8 cycles; done pulse 1 cycle; sum=0x00, carry_out=0.
- a=0xFF, b=0x01 -> sum=0x00, carry_out=1. Also a=0x80, b=0x80 -> sum=0x00, carry_out=1. Also a=0xA5, b=0x5A -> sum=0xFF, carry_out=0.
- Start 0x12+0x34, pulse start again at RUN cycle 3 with a=0xFF, b=0xFF, and change a/b mid-run -> single done; sum=0x46, carry_out=0; no second operation.
- start held high 30 cycles with a=0x0F, b=0x01 -> done pulses every 10 cycles; sum=0x10 each time; busy low for exactly 2 cycles between runs.
- Start 0xF0+0x20, assert rst_n low at RUN cycle 4 -> outputs 0 immediately, no done. After release, start 0x01+0x02 -> sum=0x03, carry_out=0.
- After a completed op (sum=0x46), idle 20 cycles with a/b toggling -> sum/carry_out stable, done stays 0.
